mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and runs the req/ack handshakes with instruction and data memory. Each state drives the per-cycle strobes for the PC, IR, register file and data port. It sits between the combinational decode/ALU datapath and the memory ports, and owns the retired-instruction counter and trap reporting.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 15, max cycles a memory request may wait for ack (used only with MCSEQ_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from IR, stable from DECODE until next FETCH
- br_taken  in  1  ALU compare result, valid in EXEC
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- reg_we  out  1  register file write strobe
- alu_src  out  1  ALU B operand: 0 = rs2, 1 = imm
- wb_sel  out  2  00 ALU, 01 load data, 10 PC+4
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 PC+4, 01 branch target, 10 JAL target
- retire  out  1  one-cycle pulse per completed instruction
- retired  out  CNT_W  count of retired instructions
- trap  out  1  high while in TRAP
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout
- state  out  3  current state encoding (debug)

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Codes 6 and other unused codes go to TRAP with cause 01.
- IDLE: all strobes low. Goes to FETCH unconditionally.
- FETCH: imem_req=1. When imem_ack=1: ir_we=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE: classify opcode into R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BR (1100011), LUI (0110111) and JAL (1101111). Latch the class.
  - Any other opcode: go to TRAP with trap_cause=01.
  - Otherwise go to EXEC.
- EXEC: alu_src=1 for I, LOAD, STORE and LUI; 0 otherwise.
  - R, I, LUI, JAL: go to WB.
  - LOAD, STORE: go to MEM.
  - BR: pc_we=1, pc_sel = br_taken ? 01 : 00, retire=1, then go to FETCH.
- MEM: dmem_req=1 and dmem_we = STORE; alu_src=1 is held.
  - On dmem_ack with STORE: pc_we=1, pc_sel=00, retire=1, then go to FETCH.
  - On dmem_ack with LOAD: go to WB.
- WB: reg_we=1 and pc_we=1, then go to FETCH. retire=1.
  - wb_sel: 01 for LOAD, 10 for JAL, 00 otherwise.
  - pc_sel: 10 for JAL, 00 otherwise.
- TRAP: all strobes low, trap=1. Exit only through rst.
- retired increments by 1 on every retire pulse and wraps from 2^CNT_W-1 to 0.
- An ack that arrives while the matching req is low is ignored.

## Timing
- Reset, asynchronous:
  - state goes to IDLE immediately.
  - Every output goes to 0 and retired goes to 0.
  - A request in flight at reset is abandoned, with no strobe after reset.
- Outputs are Moore in state, except that ir_we, retire and the pc_we / pc_sel for BR and STORE are qualified in-cycle by ack or state.
- req stays high until the cycle in which ack is sampled high, and drops the next cycle.
- Zero-wait memory: the first FETCH follows 1 cycle after reset release.
  - BR: 3 cycles.
  - R, I, LUI, JAL, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each cycle of ack delay adds 1.

## Configuration
- MCSEQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle req is high without ack.
  - If ack has not arrived when the counter reaches TIMEOUT, go to TRAP next cycle with trap_cause=10 and drop req.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins; no trap.
- MCSEQ_TIMEOUT_EN undefined: no counter; waits indefinitely; trap_cause never 10.

## Test plan
- Reset release, imem_ack tied 1, opcode 0110011 -> state sequence 0,1,2,3,5,1; reg_we=1 and retire=1 in the WB cycle; retired=1.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; wb_sel=01 in WB; total 8 cycles per instruction.
- BR with br_taken=1, then BR with br_taken=0 -> pc_sel=01 then 00, each in its EXEC cycle; 3 cycles each; no reg_we.
- opcode 1111111 -> TRAP after DECODE; trap=1, trap_cause=01; stays put with imem_ack=1 until rst.
- Assert rst mid-MEM with a STORE (dmem_req=1) -> dmem_req, dmem_we and retired go to 0 asynchronously; FETCH resumes 1 cycle after release.
- With MCSEQ_TIMEOUT_EN and TIMEOUT=15, imem_ack held 0 -> TRAP with trap_cause=10 after 16 cycles of imem_req. The same run with ack on the 15th wait cycle -> no trap.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes.
// Latency BR 3, ALU/STORE 4, LOAD 5 cycles plus ack waits; MCSEQ_TIMEOUT_EN adds a bus watchdog.
module mc_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             alu_src,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R     = 3'd0,
    C_I     = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_BR    = 3'd4,
    C_LUI   = 3'd5,
    C_JAL   = 3'd6,
    C_ILL   = 3'd7
  } cls_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       alu_src;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       trap;
  } mo_t;

  state_t     st;
  cls_t       cls;
  cls_t       dec;
  mo_t        mo;
  logic [1:0] cause;
  logic       tmo;
  logic       br_retire;
  logic       st_retire;

  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    case (op)
      7'b0110011: c = C_R;
      7'b0010011: c = C_I;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BR;
      7'b0110111: c = C_LUI;
      7'b1101111: c = C_JAL;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  // Moore strobes of a state, computed for the state being entered so they leave a flop.
  function automatic mo_t outs(input state_t s, input cls_t c);
    mo_t m;
    m = '0;
    case (s)
      S_FETCH: m.imem_req = 1'b1;
      S_EXEC:  m.alu_src = (c == C_I) || (c == C_LOAD) || (c == C_STORE) || (c == C_LUI);
      S_MEM: begin
        m.dmem_req = 1'b1;
        m.dmem_we  = (c == C_STORE);
        m.alu_src  = 1'b1;
      end
      S_WB: begin
        m.reg_we = 1'b1;
        m.pc_we  = 1'b1;
        m.wb_sel = (c == C_LOAD) ? 2'b01 : ((c == C_JAL) ? 2'b10 : 2'b00);
        m.pc_sel = (c == C_JAL) ? 2'b10 : 2'b00;
      end
      S_TRAP:  m.trap = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  assign dec = classify(opcode);

`ifdef MCSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 2);

  logic [TW-1:0] wcnt;
  logic          wait_cyc;

  // Counts cycles spent waiting; any non-waiting cycle clears it, so each FETCH/MEM entry starts at 0.
  assign wait_cyc = ((st == S_FETCH) && !imem_ack) || ((st == S_MEM) && !dmem_ack);
  assign tmo      = wait_cyc && (wcnt == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (wait_cyc) begin
      wcnt <= wcnt + TW'(1);
    end else begin
      wcnt <= '0;
    end
  end
`else
  // Watchdog compiled out: requests wait forever.
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= S_IDLE;
      cls   <= C_R;
      mo    <= '0;
      cause <= 2'b00;
    end else begin
      case (st)
        S_IDLE: begin
          st <= S_FETCH;
          mo <= outs(S_FETCH, cls);
        end
        S_FETCH: begin
          if (imem_ack) begin
            st <= S_DECODE;
            mo <= outs(S_DECODE, cls);
          end else if (tmo) begin
            st    <= S_TRAP;
            cause <= 2'b10;
            mo    <= outs(S_TRAP, cls);
          end
        end
        S_DECODE: begin
          if (dec == C_ILL) begin
            st    <= S_TRAP;
            cause <= 2'b01;
            mo    <= outs(S_TRAP, dec);
          end else begin
            cls <= dec;
            st  <= S_EXEC;
            mo  <= outs(S_EXEC, dec);
          end
        end
        S_EXEC: begin
          case (cls)
            C_BR: begin
              st <= S_FETCH;
              mo <= outs(S_FETCH, cls);
            end
            C_LOAD, C_STORE: begin
              st <= S_MEM;
              mo <= outs(S_MEM, cls);
            end
            default: begin
              st <= S_WB;
              mo <= outs(S_WB, cls);
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (cls == C_STORE) begin
              st <= S_FETCH;
              mo <= outs(S_FETCH, cls);
            end else begin
              st <= S_WB;
              mo <= outs(S_WB, cls);
            end
          end else if (tmo) begin
            st    <= S_TRAP;
            cause <= 2'b10;
            mo    <= outs(S_TRAP, cls);
          end
        end
        S_WB: begin
          st <= S_FETCH;
          mo <= outs(S_FETCH, cls);
        end
        S_TRAP: begin
          st <= S_TRAP;
        end
        default: begin
          st    <= S_TRAP;
          cause <= 2'b01;
          mo    <= outs(S_TRAP, cls);
        end
      endcase
    end
  end

  // BR and STORE complete without a WB cycle, so their PC update and retire are decided in-cycle.
  assign br_retire = (st == S_EXEC) && (cls == C_BR);
  assign st_retire = (st == S_MEM) && (cls == C_STORE) && dmem_ack;

  assign ir_we      = (st == S_FETCH) && imem_ack;
  assign retire     = br_retire || st_retire || (st == S_WB);
  assign pc_we      = mo.pc_we || br_retire || st_retire;
  assign pc_sel     = br_retire ? {1'b0, br_taken} : mo.pc_sel;
  assign imem_req   = mo.imem_req;
  assign dmem_req   = mo.dmem_req;
  assign dmem_we    = mo.dmem_we;
  assign reg_we     = mo.reg_we;
  assign alu_src    = mo.alu_src;
  assign wb_sel     = mo.wb_sel;
  assign trap       = mo.trap;
  assign trap_cause = cause;
  assign state      = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

  a_one_port: assert property (@(posedge clk) disable iff (rst) !(imem_req && dmem_req));
  a_we_qual:  assert property (@(posedge clk) disable iff (rst) dmem_we |-> dmem_req);
  a_trap_sticky: assert property (@(posedge clk) disable iff (rst) trap |=> trap);

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-instruction schedule model driving acks, checked every cycle.
module tb_mc_sequencer;

  localparam int CW  = 4;
  localparam int TMO = 15;
`ifdef MCSEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          br_taken;
  logic          imem_ack;
  logic          dmem_ack;
  logic          imem_req;
  logic          ir_we;
  logic          dmem_req;
  logic          dmem_we;
  logic          reg_we;
  logic          alu_src;
  logic [1:0]    wb_sel;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic          retire;
  logic [CW-1:0] retired;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [2:0]    state;

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .alu_src(alu_src),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .retired(retired), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  typedef struct packed {
    logic [2:0]    state;
    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          reg_we;
    logic          alu_src;
    logic [1:0]    wb_sel;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic          retire;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired;
  } obs_t;

  int   n_chk = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b0;
  obs_t exp_o;
  int   cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
  endtask

  function automatic logic [63:0] widen(input obs_t o);
    logic [63:0] w;
    w = '0;
    w[$bits(obs_t)-1:0] = o;
    return w;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.state = state;       o.imem_req = imem_req; o.ir_we = ir_we;
    o.dmem_req = dmem_req; o.dmem_we = dmem_we;   o.reg_we = reg_we;
    o.alu_src = alu_src;   o.wb_sel = wb_sel;     o.pc_we = pc_we;
    o.pc_sel = pc_sel;     o.retire = retire;     o.trap = trap;
    o.trap_cause = trap_cause; o.retired = retired;
    return o;
  endfunction

  always @(negedge clk) if (chk_en) check("cycle", widen(dut_obs()), widen(exp_o));

  function automatic obs_t base(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.state = s;
    e.retired = CW'(cnt);
    return e;
  endfunction

  task automatic cyc(input obs_t e);
    exp_o = e;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    br_taken = 1'($urandom);
  endtask

  task automatic bump();
    cnt = (cnt + 1) % (1 << CW);
  endtask

  task automatic trap_seq(input logic [1:0] c);
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      noise();
      imem_ack = 1'b1;
      e = base(3'd7);
      e.trap = 1'b1;
      e.trap_cause = c;
      cyc(e);
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_outputs", widen(dut_obs()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    noise();
    cyc(base(3'd0));
  endtask

  // One instruction as a cycle schedule: fetch wait, decode, exec, optional mem wait, optional writeback.
  task automatic run_instr(input logic [6:0] op, input bit tk, input int di, input int dd,
                           input int abort_mem, output int cycles, output bit trapped);
    obs_t e;
    bit ld, sto, br, jal, imm, legal;
    ld  = (op == OP_LD);
    sto = (op == OP_ST);
    br  = (op == OP_BR);
    jal = (op == OP_JAL);
    imm = (op == OP_I) || ld || sto || (op == OP_LUI);
    legal = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_JAL};
    cycles = 0;
    trapped = 1'b0;
    for (int k = 0; k <= di; k++) begin
      noise();
      imem_ack = (k == di);
      e = base(3'd1);
      e.imem_req = 1'b1;
      e.ir_we = (k == di);
      cyc(e);
      cycles++;
      if (k != di && TMO_EN && k == TMO) begin
        trap_seq(2'b10);
        trapped = 1'b1;
        return;
      end
    end
    opcode = op;
    noise();
    cyc(base(3'd2));
    cycles++;
    if (!legal) begin
      trap_seq(2'b01);
      trapped = 1'b1;
      return;
    end
    noise();
    br_taken = tk;
    e = base(3'd3);
    e.alu_src = imm;
    if (br) begin
      e.pc_we = 1'b1;
      e.pc_sel = {1'b0, tk};
      e.retire = 1'b1;
    end
    cyc(e);
    cycles++;
    if (br) begin
      bump();
      return;
    end
    if (ld || sto) begin
      for (int k = 0; k <= dd; k++) begin
        if (k == abort_mem) begin
          check("pre_rst_dmem_req", 64'(dmem_req), 64'd1);
          return;
        end
        noise();
        dmem_ack = (k == dd);
        e = base(3'd4);
        e.dmem_req = 1'b1;
        e.dmem_we = sto;
        e.alu_src = 1'b1;
        if (sto && k == dd) begin
          e.pc_we = 1'b1;
          e.retire = 1'b1;
        end
        cyc(e);
        cycles++;
        if (k != dd && TMO_EN && k == TMO) begin
          trap_seq(2'b10);
          trapped = 1'b1;
          return;
        end
      end
      if (sto) begin
        bump();
        return;
      end
    end
    noise();
    e = base(3'd5);
    e.reg_we = 1'b1;
    e.pc_we = 1'b1;
    e.retire = 1'b1;
    e.wb_sel = ld ? 2'b01 : (jal ? 2'b10 : 2'b00);
    e.pc_sel = jal ? 2'b10 : 2'b00;
    cyc(e);
    cycles++;
    bump();
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 2));
    if (r < 18) return int'($urandom_range(3, 6));
    return int'($urandom_range(14, 16));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [6:0] ops [7];
    logic [6:0] op;
    int cy;
    bit tr;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_JAL};
    rst = 1'b1;
    opcode = 7'd0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    do_reset();

    run_instr(OP_R, 1'b0, 0, 0, -1, cy, tr);
    check("r_cycles", 64'(cy), 64'd4);
    check("r_retired", 64'(retired), 64'd1);
    run_instr(OP_LD, 1'b0, 0, 3, -1, cy, tr);
    check("load_dly3_cycles", 64'(cy), 64'd8);
    run_instr(OP_BR, 1'b1, 0, 0, -1, cy, tr);
    check("br_taken_cycles", 64'(cy), 64'd3);
    run_instr(OP_BR, 1'b0, 0, 0, -1, cy, tr);
    check("br_not_cycles", 64'(cy), 64'd3);
    run_instr(OP_ST, 1'b0, 0, 0, -1, cy, tr);
    check("store_cycles", 64'(cy), 64'd4);
    run_instr(OP_JAL, 1'b0, 1, 0, -1, cy, tr);
    check("jal_dly1_cycles", 64'(cy), 64'd5);
    check("retired_after_6", 64'(retired), 64'd6);
    run_instr(7'b1111111, 1'b0, 0, 0, -1, cy, tr);
    check("illegal_trapped", 64'(tr), 64'd1);
    check("illegal_cause", 64'(trap_cause), 64'd1);

    do_reset();
    run_instr(OP_R, 1'b0, 0, 0, -1, cy, tr);
    run_instr(OP_I, 1'b0, 0, 0, -1, cy, tr);
    run_instr(OP_ST, 1'b0, 0, 5, 2, cy, tr);
    do_reset();
    run_instr(OP_LUI, 1'b0, 0, 0, -1, cy, tr);
    check("post_rst_lui_cycles", 64'(cy), 64'd4);

`ifdef MCSEQ_TIMEOUT_EN
    run_instr(OP_I, 1'b0, 16, 0, -1, cy, tr);
    check("tmo_fetch_trapped", 64'(tr), 64'd1);
    check("tmo_fetch_cause", 64'(trap_cause), 64'd2);
    do_reset();
    run_instr(OP_I, 1'b0, 15, 0, -1, cy, tr);
    check("tmo_edge_no_trap", 64'(tr), 64'd0);
    check("tmo_edge_cycles", 64'(cy), 64'd19);
    run_instr(OP_LD, 1'b0, 0, 16, -1, cy, tr);
    check("tmo_mem_trapped", 64'(tr), 64'd1);
    do_reset();
`endif

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = 7'h7f;
        for (int t = 0; t < 8; t++) begin
          op = 7'($urandom);
          if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_JAL})) break;
          op = 7'h7f;
        end
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      run_instr(op, 1'($urandom), pick_delay(), pick_delay(), -1, cy, tr);
      if (tr) do_reset();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
